// File: rtl/apb_timer_slave.sv
// APB timer slave: 32-bit down-counter with 8-bit prescaler, one-shot/auto-reload,
// sticky expiry flag and level interrupt. Read data is captured in the setup cycle.
module apb_timer_slave #(
   parameter int unsigned PSEL_W  = 3,
   parameter int unsigned SEL_IDX = 0
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic [PSEL_W-1:0] PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              IRQ
);
   localparam int unsigned DW = 32;
   localparam int unsigned PW = 8;
   localparam int unsigned SW = (PSEL_W > 1) ? $clog2(PSEL_W) : 1;

   localparam logic [2:0] A_CTRL    = 3'd0;
   localparam logic [2:0] A_LOAD    = 3'd1;
   localparam logic [2:0] A_VALUE   = 3'd2;
   localparam logic [2:0] A_STATUS  = 3'd3;
   localparam logic [2:0] A_PRESC   = 3'd4;
   localparam logic [2:0] A_SCRATCH = 3'd5;

   logic          ctrl_en, ctrl_reload, ctrl_ie;
   logic [DW-1:0] load_reg, value_reg, scratch_reg;
   logic [PW-1:0] presc_reg, pcnt;
   logic          expired;

   logic          sel, wr, rd;
   logic [2:0]    idx;
   logic          wr_ctrl, wr_load, wr_status, wr_presc, wr_scratch;
   logic          tick, tick_eff, expire;
   logic [DW-1:0] rdata_c;
   logic          unused_bits;

   assign sel = PSEL[SW'(SEL_IDX)];
   assign wr  = sel & PENABLE & PWRITE;
   assign rd  = sel & ~PENABLE & ~PWRITE;
   assign idx = PADDR[4:2];

   assign wr_ctrl    = wr && (idx == A_CTRL);
   assign wr_load    = wr && (idx == A_LOAD);
   assign wr_status  = wr && (idx == A_STATUS);
   assign wr_presc   = wr && (idx == A_PRESC);
   assign wr_scratch = wr && (idx == A_SCRATCH);

   // A LOAD write or a disabling CTRL write on a tick edge suppresses that tick.
   assign tick     = ctrl_en && (pcnt == presc_reg);
   assign tick_eff = tick && !wr_load && !(wr_ctrl && !PWDATA[0]);
   assign expire   = tick_eff && (value_reg == '0);

   assign IRQ = expired & ctrl_ie;

   assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PSEL};

   // Register read mux; unmapped offsets read zero.
   always_comb begin
      rdata_c = '0;
      case (idx)
         A_CTRL:    rdata_c = {29'd0, ctrl_ie, ctrl_reload, ctrl_en};
         A_LOAD:    rdata_c = load_reg;
         A_VALUE:   rdata_c = value_reg;
         A_STATUS:  rdata_c = {31'd0, expired};
         A_PRESC:   rdata_c = {24'd0, presc_reg};
         A_SCRATCH: rdata_c = scratch_reg;
         default:   rdata_c = '0;
      endcase
   end

   // Later assignments in this block take priority: bus writes override the counter.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ctrl_en     <= 1'b0;
         ctrl_reload <= 1'b0;
         ctrl_ie     <= 1'b0;
         load_reg    <= '0;
         value_reg   <= '0;
         scratch_reg <= '0;
         presc_reg   <= '0;
         pcnt        <= '0;
         expired     <= 1'b0;
         PRDATA      <= '0;
      end else begin
         if (ctrl_en) begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
         end
         if (tick_eff) begin
            if (value_reg != '0) begin
               value_reg <= value_reg - DW'(1);
            end else if (ctrl_reload) begin
               value_reg <= load_reg;
            end else begin
               ctrl_en <= 1'b0;
            end
         end
         if (expire) begin
            expired <= 1'b1;
         end else if (wr_status && PWDATA[0]) begin
            expired <= 1'b0;
         end
         if (wr_ctrl) begin
            ctrl_en     <= PWDATA[0];
            ctrl_reload <= PWDATA[1];
            ctrl_ie     <= PWDATA[2];
            if (PWDATA[0] && !ctrl_en) begin
               pcnt <= '0;
            end
         end
         if (wr_load) begin
            load_reg  <= PWDATA;
            value_reg <= PWDATA;
            pcnt      <= '0;
         end
         if (wr_presc) begin
            presc_reg <= PWDATA[PW-1:0];
         end
         if (wr_scratch) begin
            scratch_reg <= PWDATA;
         end
         if (rd) begin
            PRDATA <= rdata_c;
         end
      end
   end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: read expectations go through a scoreboard queue,
// all timing is scheduled against an edge counter.
module tb_apb_timer_slave;
   localparam int unsigned PSEL_W = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [PSEL_W-1:0] psel;
   logic              penable;
   logic              pwrite;
   logic [31:0]       paddr;
   logic [31:0]       pwdata;
   logic [31:0]       prdata;
   logic              irq;

   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;
   logic [PSEL_W-1:0] sel_pat;
   logic [31:0]       last_rd;
   logic [31:0]       exp_q[$];
   string             tag_q[$];

   apb_timer_slave #(.PSEL_W(PSEL_W), .SEL_IDX(1)) dut (
      .HCLK    (clk),
      .HRESETn (rst_n),
      .PSEL    (psel),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PRDATA  (prdata),
      .IRQ     (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   task automatic idle();
      psel    = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
   endtask

   // Returns 1ns after edge n; a late call means the schedule is broken.
   task automatic wait_until(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
      assert (cyc == n) else begin
         errors++;
         $error("FAIL sched cyc=%0d target=%0d", cyc, n);
      end
   endtask

   // Write whose access phase commits on edge k.
   task automatic write_at(input logic [31:0] addr, input logic [31:0] data, input int k);
      wait_until(k - 2);
      @(negedge clk);
      psel = sel_pat; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      @(negedge clk);
      penable = 1'b1;
      @(posedge clk);
      #1;
      idle();
   endtask

   // Read whose setup phase captures on edge k (state left by edge k-1).
   task automatic read_at(input logic [31:0] addr, input logic [31:0] expv, input string tag, input int k);
      logic [31:0] e;
      string       t;
      wait_until(k - 1);
      @(negedge clk);
      psel = sel_pat; penable = 1'b0; pwrite = 1'b0; paddr = addr;
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, prdata, e);
      last_rd = e;
      penable = 1'b1;
      @(posedge clk);
      #1;
      check({t, "_hold"}, prdata, e);
      idle();
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      write_at(addr, data, cyc + 2);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] expv, input string tag);
      read_at(addr, expv, tag, cyc + 1);
   endtask

   initial begin
      int e0;
      logic [31:0] ev;
      idle();
      paddr   = '0;
      pwdata  = '0;
      sel_pat = 3'b010;
      last_rd = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_prdata", prdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Scratch loopback, unmapped offsets, read-only VALUE, ignored address bits
      wr(32'h14, 32'hA5A5_5A5A);
      rd(32'h14, 32'hA5A5_5A5A, "scratch");
      rd(32'h1C, 32'h0, "unmapped_1c");
      wr(32'h18, 32'hFFFF_FFFF);
      rd(32'h18, 32'h0, "unmapped_18");
      wr(32'h08, 32'h0000_1234);
      rd(32'h08, 32'h0, "value_ro");
      rd(32'h1000_0034, 32'hA5A5_5A5A, "scratch_alias");

      // One-shot: PRESC=0, LOAD=3, CTRL=en|ie -> IRQ exactly 4 edges later
      wr(32'h10, 32'd0);
      wr(32'h04, 32'd3);
      wr(32'h00, 32'h5);
      e0 = cyc;
      for (int k = 1; k <= 5; k++) begin
         wait_until(e0 + k);
         ev = (k >= 4) ? 32'd1 : 32'd0;
         check($sformatf("oneshot_irq_%0d", k), {31'd0, irq}, ev);
      end
      rd(32'h00, 32'h4, "oneshot_ctrl");
      rd(32'h08, 32'h0, "oneshot_value");
      rd(32'h0C, 32'h1, "oneshot_status");
      wr(32'h0C, 32'h1);
      check("oneshot_w1c_irq", {31'd0, irq}, 32'd0);
      rd(32'h0C, 32'h0, "oneshot_status_clr");

      // Auto-reload: PRESC=1, LOAD=2 -> expiry on edges e0+6, e0+12, e0+18 ...
      wr(32'h10, 32'd1);
      wr(32'h04, 32'd2);
      wr(32'h00, 32'h3);
      e0 = cyc;
      read_at(32'h0C, 32'd0, "ar_status_pre", e0 + 6);
      read_at(32'h08, 32'd2, "ar_value_reload", e0 + 8);
      read_at(32'h0C, 32'd1, "ar_status_set", e0 + 10);
      read_at(32'h08, 32'd0, "ar_value_zero", e0 + 12);
      write_at(32'h0C, 32'h1, e0 + 15);
      read_at(32'h0C, 32'd0, "ar_status_clr", e0 + 18);
      read_at(32'h08, 32'd2, "ar_value_reload2", e0 + 20);
      read_at(32'h0C, 32'd1, "ar_status_set2", e0 + 22);
      wr(32'h00, 32'h0);

      // Collisions: LOAD=0, PRESC=0, reload -> expiry on every edge
      wr(32'h0C, 32'h1);
      wr(32'h10, 32'd0);
      wr(32'h04, 32'd0);
      wr(32'h00, 32'h3);
      e0 = cyc;
      write_at(32'h0C, 32'h1, e0 + 3);
      read_at(32'h0C, 32'd1, "col_status_set_wins", e0 + 4);
      write_at(32'h04, 32'd7, e0 + 7);
      read_at(32'h08, 32'd7, "col_load_value", e0 + 8);
      write_at(32'h00, 32'h0, e0 + 11);
      read_at(32'h08, 32'd4, "col_ctrl_off_value", e0 + 12);
      rd(32'h04, 32'd7, "col_load_reg");
      wr(32'h0C, 32'h1);
      rd(32'h0C, 32'd0, "col_status_clr");

      // Select isolation: accesses on the wrong PSEL bit do nothing
      sel_pat = 3'b001;
      wr(32'h14, 32'hDEAD_BEEF);
      wr(32'h00, 32'h7);
      wr(32'h04, 32'h55);
      rd(32'h14, last_rd, "iso_prdata");
      sel_pat = 3'b010;
      rd(32'h14, 32'hA5A5_5A5A, "iso_scratch");
      rd(32'h00, 32'h0, "iso_ctrl");
      rd(32'h04, 32'd7, "iso_load");

      // Reset mid-count and mid-write
      wr(32'h10, 32'd0);
      wr(32'h04, 32'd0);
      wr(32'h00, 32'h7);
      wr(32'h04, 32'd20);
      check("pre_rst_irq", {31'd0, irq}, 32'd1);
      @(negedge clk);
      psel = sel_pat; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h1111_1111;
      @(negedge clk);
      penable = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_irq", {31'd0, irq}, 32'd0);
      check("midrst_prdata", prdata, 32'd0);
      @(negedge clk);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rd(32'(i * 4), 32'd0, $sformatf("post_rst_%0d", i));
      end
      check("post_rst_irq", {31'd0, irq}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
